// File: rtl/rank_sort_pipe_pkg.sv
// rank_sort_pkg: shared helpers for the rank_sort_pipe sorter.
// Elements travel as parallel data and index planes, because package types cannot follow module parameters.
package rank_sort_pkg;

    function automatic int layers(input int n);
        return n + 1;
    endfunction

    function automatic int clamp_rank(input int r, input int n);
        return (r >= n) ? n - 1 : r;
    endfunction

endpackage

// File: rtl/rank_sort_pipe_layer.sv
// rank_sort_layer: one registered compare-and-swap layer of the odd-even transposition network.
// With RANK_SORT_PIPE_INDEX_EN defined, the original element positions are swapped along with the data.
module rank_sort_layer
    import rank_sort_pkg::*;
#(
    parameter int NUMBER_WIDTH   = 10,
    parameter int NUMBERS_AMOUNT = 9,
    parameter int SIGNED         = 0,
`ifdef RANK_SORT_PIPE_INDEX_EN
    parameter int RANK_WIDTH     = $clog2(NUMBERS_AMOUNT),
`endif
    parameter int ODD            = 1
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic                                         en_i,
    input  logic                                         descend_i,
    input  logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0]  data_i,
`ifdef RANK_SORT_PIPE_INDEX_EN
    input  logic [NUMBERS_AMOUNT-1:0][RANK_WIDTH-1:0]    index_i,
    output logic [NUMBERS_AMOUNT-1:0][RANK_WIDTH-1:0]    index_o,
`endif
    output logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0]  data_o
);
    localparam int N = NUMBERS_AMOUNT;

    logic [N-1:0]                   swap;
    logic [N-1:0][NUMBER_WIDTH-1:0] nxt;
`ifdef RANK_SORT_PIPE_INDEX_EN
    logic [N-1:0][RANK_WIDTH-1:0]   nxt_idx;
`endif

    // swap[i] marks a pair whose lower slot is i; the modulo indices stay in range and
    // swap[N-1] is always 0, so edge elements simply pass through.
    for (genvar i = 0; i < N; i++) begin : g_pair
        if ((i % 2) != ODD && i + 1 < N) begin : g_cas
            logic gt, lt;
            assign gt = (SIGNED != 0) ? ($signed(data_i[i]) > $signed(data_i[i+1])) : (data_i[i] > data_i[i+1]);
            assign lt = (SIGNED != 0) ? ($signed(data_i[i]) < $signed(data_i[i+1])) : (data_i[i] < data_i[i+1]);
            assign swap[i] = descend_i ? lt : gt;
        end else begin : g_pass
            assign swap[i] = 1'b0;
        end
        assign nxt[i] = swap[i] ? data_i[(i+1)%N] : swap[(i+N-1)%N] ? data_i[(i+N-1)%N] : data_i[i];
`ifdef RANK_SORT_PIPE_INDEX_EN
        assign nxt_idx[i] = swap[i] ? index_i[(i+1)%N] : swap[(i+N-1)%N] ? index_i[(i+N-1)%N] : index_i[i];
`endif
    end

    // Register the layer result; hold while the pipeline is stalled
    always_ff @(posedge clk_i) begin
        if (rst_i)
            data_o <= '0;
        else if (en_i)
            data_o <= nxt;
    end

`ifdef RANK_SORT_PIPE_INDEX_EN
    // Register the permuted original positions alongside the data
    always_ff @(posedge clk_i) begin
        if (rst_i)
            index_o <= '0;
        else if (en_i)
            index_o <= nxt_idx;
    end
`endif

endmodule

// File: rtl/rank_sort_pipe.sv
// rank_sort_pipe: fully pipelined odd-even transposition sorter with asc/desc mode, rank select and valid/ready.
// Defining RANK_SORT_PIPE_INDEX_EN adds argsort outputs index_o and rank_index_o.
module rank_sort_pipe
    import rank_sort_pkg::*;
#(
    parameter int NUMBER_WIDTH   = 10,
    parameter int NUMBERS_AMOUNT = 9,
    parameter int SIGNED         = 0,
    parameter int RANK_WIDTH     = $clog2(NUMBERS_AMOUNT)
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic                                         data_valid_i,
    output logic                                         data_ready_o,
    input  logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0]  data_i,
    input  logic                                         descend_i,
    input  logic [RANK_WIDTH-1:0]                        rank_i,
`ifdef RANK_SORT_PIPE_INDEX_EN
    output logic [NUMBERS_AMOUNT-1:0][RANK_WIDTH-1:0]    index_o,
    output logic [RANK_WIDTH-1:0]                        rank_index_o,
`endif
    output logic                                         data_valid_o,
    input  logic                                         data_ready_i,
    output logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0]  data_o,
    output logic [NUMBER_WIDTH-1:0]                      rank_data_o
);
    localparam int N = NUMBERS_AMOUNT;
    localparam int S = layers(N);

    logic                                   en;
    logic [S-1:0]                           vld;
    logic [N-1:0]                           dsc;
    logic [S-1:0][RANK_WIDTH-1:0]           rnk;
    logic [RANK_WIDTH-1:0]                  rank_c;
    logic [N-1:0][NUMBER_WIDTH-1:0]         in_q;
    logic [S-1:0][N-1:0][NUMBER_WIDTH-1:0]  dat;

    // A single enable freezes every stage so a stalled output keeps its whole pipeline behind it
    assign en           = !vld[S-1] || data_ready_i;
    assign data_ready_o = en;
    assign rank_c       = RANK_WIDTH'(clamp_rank(int'(rank_i), N));

    // Input register plus the valid, descend and rank sideband chains
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld  <= '0;
            dsc  <= '0;
            rnk  <= '0;
            in_q <= '0;
        end else if (en) begin
            vld  <= {vld[S-2:0], data_valid_i};
            dsc  <= {dsc[N-2:0], descend_i};
            rnk  <= {rnk[S-2:0], rank_c};
            in_q <= data_i;
        end
    end

    assign dat[0] = in_q;

`ifdef RANK_SORT_PIPE_INDEX_EN
    logic [S-1:0][N-1:0][RANK_WIDTH-1:0] idx;
    logic [N-1:0][RANK_WIDTH-1:0]        idx_q, ident;

    // Each element is tagged with its arrival position
    always_comb begin
        for (int i = 0; i < N; i++)
            ident[i] = RANK_WIDTH'(i);
    end

    // Capture the position tags together with the input data
    always_ff @(posedge clk_i) begin
        if (rst_i)
            idx_q <= '0;
        else if (en)
            idx_q <= ident;
    end

    assign idx[0]       = idx_q;
    assign index_o      = idx[S-1];
    assign rank_index_o = idx[S-1][rnk[S-1]];
`endif

    // Layer k sees the descend bit of the transaction currently in stage k-1
    for (genvar k = 1; k <= N; k++) begin : g_layer
        rank_sort_layer #(
            .NUMBER_WIDTH   (NUMBER_WIDTH),
            .NUMBERS_AMOUNT (N),
            .SIGNED         (SIGNED),
`ifdef RANK_SORT_PIPE_INDEX_EN
            .RANK_WIDTH     (RANK_WIDTH),
`endif
            .ODD            (k % 2)
        ) u_layer (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .en_i      (en),
            .descend_i (dsc[k-1]),
            .data_i    (dat[k-1]),
`ifdef RANK_SORT_PIPE_INDEX_EN
            .index_i   (idx[k-1]),
            .index_o   (idx[k]),
`endif
            .data_o    (dat[k])
        );
    end

    assign data_o       = dat[S-1];
    assign data_valid_o = vld[S-1];
    assign rank_data_o  = dat[S-1][rnk[S-1]];

endmodule

// File: tb/tb_rank_sort_pipe.sv
// tb_rank_sort_pipe: directed self-checking bench for rank_sort_pipe (N=9 unsigned, N=4 signed/unsigned).
module tb_rank_sort_pipe;
    localparam int W   = 10;
    localparam int N   = 9;
    localparam int RW  = $clog2(N);
    localparam int N4  = 4;
    localparam int RW4 = $clog2(N4);

    typedef logic [N-1:0][W-1:0]  vec_t;
    typedef logic [N4-1:0][W-1:0] vec4_t;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    logic          dv, dr_o, desc, dv_o, dr_i;
    logic [RW-1:0] rk;
    vec_t          din, dout;
    logic [W-1:0]  rdo;

    logic           s_dv, s_desc, sdr_o, sdv_o, udr_o, udv_o;
    logic [RW4-1:0] s_rk;
    vec4_t          s_din, sdo, udo;
    logic [W-1:0]   srdo, urdo;

`ifdef RANK_SORT_PIPE_INDEX_EN
    logic [N-1:0][RW-1:0]   ix;
    logic [RW-1:0]          rix;
    logic [N4-1:0][RW4-1:0] s_ix, u_ix;
    logic [RW4-1:0]         s_rix, u_rix;
`endif

    int cmp = 0;
    int bad = 0;

    rank_sort_pipe #(.NUMBER_WIDTH(W), .NUMBERS_AMOUNT(N), .SIGNED(0)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .data_valid_i(dv), .data_ready_o(dr_o), .data_i(din),
        .descend_i(desc), .rank_i(rk),
`ifdef RANK_SORT_PIPE_INDEX_EN
        .index_o(ix), .rank_index_o(rix),
`endif
        .data_valid_o(dv_o), .data_ready_i(dr_i), .data_o(dout), .rank_data_o(rdo)
    );

    rank_sort_pipe #(.NUMBER_WIDTH(W), .NUMBERS_AMOUNT(N4), .SIGNED(1)) dut_s (
        .clk_i(clk_i), .rst_i(rst_i), .data_valid_i(s_dv), .data_ready_o(sdr_o), .data_i(s_din),
        .descend_i(s_desc), .rank_i(s_rk),
`ifdef RANK_SORT_PIPE_INDEX_EN
        .index_o(s_ix), .rank_index_o(s_rix),
`endif
        .data_valid_o(sdv_o), .data_ready_i(1'b1), .data_o(sdo), .rank_data_o(srdo)
    );

    rank_sort_pipe #(.NUMBER_WIDTH(W), .NUMBERS_AMOUNT(N4), .SIGNED(0)) dut_u (
        .clk_i(clk_i), .rst_i(rst_i), .data_valid_i(s_dv), .data_ready_o(udr_o), .data_i(s_din),
        .descend_i(s_desc), .rank_i(s_rk),
`ifdef RANK_SORT_PIPE_INDEX_EN
        .index_o(u_ix), .rank_index_o(u_rix),
`endif
        .data_valid_o(udv_o), .data_ready_i(1'b1), .data_o(udo), .rank_data_o(urdo)
    );

    function automatic vec_t sort_model(input vec_t v, input logic d);
        vec_t r = v;
        logic [W-1:0] t;
        for (int i = 0; i < N; i++)
            for (int j = i + 1; j < N; j++)
                if (d ? (r[j] > r[i]) : (r[j] < r[i])) begin
                    t = r[i]; r[i] = r[j]; r[j] = t;
                end
        return r;
    endfunction

    task automatic test_reset();
        rst_i = 1'b1; dv = 1'b1; din = '1; desc = 1'b0; rk = '0; dr_i = 1'b0;
        s_dv = 1'b1; s_din = '1; s_desc = 1'b0; s_rk = '0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0; dv = 1'b0; s_dv = 1'b0;
        #1;
        cmp++; if (dv_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", dv_o); end
        cmp++; if (dout !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", dout); end
        cmp++; if (rdo !== '0) begin bad++; $display("FAIL reset_rank: got %h want 0", rdo); end
        cmp++; if (dr_o !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", dr_o); end
        cmp++; if (sdv_o !== 1'b0 || udv_o !== 1'b0) begin bad++; $display("FAIL reset_valid4: got %b%b want 00", sdv_o, udv_o); end
`ifdef RANK_SORT_PIPE_INDEX_EN
        cmp++; if (ix !== '0) begin bad++; $display("FAIL reset_index: got %h want 0", ix); end
`endif
        dr_i = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_ascending();
        int a[N] = '{3, 9, 1, 7, 5, 2, 8, 6, 4};
        vec_t e;
        for (int i = 0; i < N; i++) begin din[i] = W'(a[i]); e[i] = W'(i + 1); end
        dv = 1'b1; desc = 1'b0; rk = RW'(4);
        @(posedge clk_i); #1;
        dv = 1'b0;
        repeat (8) @(posedge clk_i);
        #1;
        cmp++; if (dv_o !== 1'b0) begin bad++; $display("FAIL asc_early_valid: got %b want 0", dv_o); end
        @(posedge clk_i); #1;
        cmp++; if (dv_o !== 1'b1) begin bad++; $display("FAIL asc_valid: got %b want 1", dv_o); end
        cmp++; if (dout !== e) begin bad++; $display("FAIL asc_data: got %h want %h", dout, e); end
        cmp++; if (rdo !== W'(5)) begin bad++; $display("FAIL asc_rank: got %0d want 5", rdo); end
`ifdef RANK_SORT_PIPE_INDEX_EN
        begin
            int p[N] = '{2, 5, 0, 8, 4, 7, 3, 6, 1};
            logic [N-1:0][RW-1:0] ei;
            for (int i = 0; i < N; i++) ei[i] = RW'(p[i]);
            cmp++; if (ix !== ei) begin bad++; $display("FAIL asc_index: got %h want %h", ix, ei); end
            cmp++; if (rix !== RW'(4)) begin bad++; $display("FAIL asc_rank_index: got %0d want 4", rix); end
        end
`endif
        @(posedge clk_i); #1;
        cmp++; if (dv_o !== 1'b0) begin bad++; $display("FAIL asc_single_beat: got %b want 0", dv_o); end
    endtask

    task automatic test_signed();
        vec4_t es, eu;
        s_din[0] = 10'h3FE; s_din[1] = 10'd5; s_din[2] = 10'd0; s_din[3] = 10'h3F9;
        es[0] = 10'd5; es[1] = 10'd0; es[2] = 10'h3FE; es[3] = 10'h3F9;
        eu[0] = 10'h3FE; eu[1] = 10'h3F9; eu[2] = 10'd5; eu[3] = 10'd0;
        s_dv = 1'b1; s_desc = 1'b1; s_rk = '0;
        @(posedge clk_i); #1;
        s_dv = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        cmp++; if (sdv_o !== 1'b0) begin bad++; $display("FAIL sgn_early_valid: got %b want 0", sdv_o); end
        @(posedge clk_i); #1;
        cmp++; if (sdv_o !== 1'b1) begin bad++; $display("FAIL sgn_valid: got %b want 1", sdv_o); end
        cmp++; if (sdo !== es) begin bad++; $display("FAIL sgn_data: got %h want %h", sdo, es); end
        cmp++; if (srdo !== W'(5)) begin bad++; $display("FAIL sgn_rank: got %h want 005", srdo); end
        cmp++; if (udo !== eu) begin bad++; $display("FAIL uns_data: got %h want %h", udo, eu); end
        cmp++; if (urdo !== 10'h3FE) begin bad++; $display("FAIL uns_rank: got %h want 3fe", urdo); end
    endtask

    task automatic stream(input int n, input int st, input int sl, output int first, output int last, output int got);
        vec_t pd[20];
        logic [RW-1:0] pr[20];
        vec_t q_d[$];
        logic [W-1:0] q_r[$];
        vec_t s, hold_d, ed;
        logic [W-1:0] hold_r, er;
        int sent = 0;
        int cyc = 0;
        int c;
        first = -1; last = -1; got = 0;
        hold_d = '0; hold_r = '0;
        for (int t = 0; t < n; t++) begin
            for (int i = 0; i < N; i++) pd[t][i] = W'($urandom_range(0, 1023));
            pr[t] = RW'($urandom_range(0, 15));
        end
        while ((sent < n || q_d.size() != 0) && cyc < 200) begin
            cyc++;
            dr_i = (cyc >= st && cyc < st + sl) ? 1'b0 : 1'b1;
            if (sent < n) begin
                dv = 1'b1; din = pd[sent]; desc = sent[0]; rk = pr[sent];
            end else
                dv = 1'b0;
            #1;
            if (!dr_i) begin
                if (cyc == st) begin hold_d = dout; hold_r = rdo; end
                cmp++; if (dr_o !== 1'b0 || dv_o !== 1'b1) begin bad++; $display("FAIL stall_ready: cyc %0d ready %b valid %b want 0 1", cyc, dr_o, dv_o); end
                cmp++; if (dout !== hold_d || rdo !== hold_r) begin bad++; $display("FAIL stall_hold: cyc %0d got %h/%h want %h/%h", cyc, dout, rdo, hold_d, hold_r); end
            end
            if (dv && dr_o) begin
                s = sort_model(pd[sent], sent[0]);
                c = (int'(pr[sent]) >= N) ? N - 1 : int'(pr[sent]);
                q_d.push_back(s);
                q_r.push_back(s[c]);
                sent++;
            end
            if (dv_o && dr_i) begin
                if (q_d.size() == 0) begin
                    cmp++; bad++; $display("FAIL stream_extra: cyc %0d got %h want none", cyc, dout);
                end else begin
                    ed = q_d.pop_front(); er = q_r.pop_front();
                    cmp++; if (dout !== ed) begin bad++; $display("FAIL stream_data: out %0d got %h want %h", got, dout, ed); end
                    cmp++; if (rdo !== er) begin bad++; $display("FAIL stream_rank: out %0d got %h want %h", got, rdo, er); end
                end
                got++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            @(posedge clk_i); #1;
        end
        dv = 1'b0; dr_i = 1'b1;
    endtask

    task automatic test_back_to_back();
        int f, l, g;
        stream(20, 0, 0, f, l, g);
        cmp++; if (g !== 20) begin bad++; $display("FAIL b2b_count: got %0d want 20", g); end
        cmp++; if (l - f !== 19) begin bad++; $display("FAIL b2b_span: got %0d want 19", l - f); end
    endtask

    task automatic test_backpressure();
        int f, l, g;
        stream(20, 15, 5, f, l, g);
        cmp++; if (g !== 20) begin bad++; $display("FAIL bp_count: got %0d want 20", g); end
        cmp++; if (l - f !== 24) begin bad++; $display("FAIL bp_span: got %0d want 24", l - f); end
    endtask

    task automatic test_ties();
        vec_t e;
        for (int i = 0; i < N; i++) begin din[i] = 10'h155; e[i] = 10'h155; end
        dv = 1'b1; desc = 1'b0; rk = RW'(15);
        @(posedge clk_i); #1;
        dv = 1'b0;
        repeat (9) @(posedge clk_i);
        #1;
        cmp++; if (dv_o !== 1'b1) begin bad++; $display("FAIL ties_valid: got %b want 1", dv_o); end
        cmp++; if (dout !== e) begin bad++; $display("FAIL ties_data: got %h want %h", dout, e); end
        cmp++; if (rdo !== 10'h155) begin bad++; $display("FAIL ties_rank: got %h want 155", rdo); end
`ifdef RANK_SORT_PIPE_INDEX_EN
        begin
            logic [N-1:0][RW-1:0] ei;
            for (int i = 0; i < N; i++) ei[i] = RW'(i);
            cmp++; if (ix !== ei) begin bad++; $display("FAIL ties_index: got %h want %h", ix, ei); end
            cmp++; if (rix !== RW'(8)) begin bad++; $display("FAIL ties_rank_index: got %0d want 8", rix); end
        end
`endif
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        vec_t e;
        for (int t = 0; t < 3; t++) begin
            dv = 1'b1; desc = 1'b0; rk = '0;
            for (int i = 0; i < N; i++) din[i] = W'(t * 16 + i + 1);
            @(posedge clk_i); #1;
        end
        rst_i = 1'b1; dv = 1'b1; din = '1;
        @(posedge clk_i); #1;
        rst_i = 1'b0; dv = 1'b0;
        cmp++; if (dv_o !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b want 0", dv_o); end
        cmp++; if (dout !== '0) begin bad++; $display("FAIL rmid_data: got %h want 0", dout); end
        repeat (15) begin
            @(posedge clk_i); #1;
            if (dv_o) seen++;
        end
        cmp++; if (seen !== 0) begin bad++; $display("FAIL rmid_ghost: got %0d outputs want 0", seen); end
        for (int i = 0; i < N; i++) begin din[i] = W'(100 - 7 * i); e[i] = W'(44 + 7 * i); end
        dv = 1'b1; desc = 1'b0; rk = RW'(2);
        @(posedge clk_i); #1;
        dv = 1'b0;
        repeat (8) @(posedge clk_i);
        #1;
        cmp++; if (dv_o !== 1'b0) begin bad++; $display("FAIL rmid_early: got %b want 0", dv_o); end
        @(posedge clk_i); #1;
        cmp++; if (dv_o !== 1'b1) begin bad++; $display("FAIL rmid_fresh_valid: got %b want 1", dv_o); end
        cmp++; if (dout !== e) begin bad++; $display("FAIL rmid_fresh_data: got %h want %h", dout, e); end
        cmp++; if (rdo !== W'(58)) begin bad++; $display("FAIL rmid_fresh_rank: got %0d want 58", rdo); end
        @(posedge clk_i); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ascending();
        test_signed();
        test_back_to_back();
        test_backpressure();
        test_ties();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule
